ahb_apb_bridge: RTL and testbench
=================================

# ahb_apb_bridge

- AHB slave that consumes the transfers issued by the team's AHB driver on `ahb_inter` and converts each one into a single APB transfer.
- Returns read data and the transfer response to the AHB master.
- Sits directly downstream of the AHB master/driver and upstream of the APB peripheral bank.
- Handles one outstanding transfer at a time and inserts AHB wait states until the APB access completes.

## Interface
Parameters:
- `data_width`, 8, width of hwdata/hrdata/pwdata/prdata.
- `addr_width`, 32, width of haddr/paddr.

Ports:
- `hclk`  in  1  clock; all logic on rising edge. One clock; reset is synchronous and active-high.
- `hreset`  in  1  synchronous, active-high reset.
- `hsel`  in  1  slave select.
- `haddr`  in  addr_width  address phase address.
- `htrans`  in  2  transfer type, package encodings.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  transfer size, log2 bytes.
- `hwdata`  in  data_width  write data, valid in the data phase.
- `hready`  in  1  bus-level ready; an address phase is accepted only when high.
- `hreadyout`  out  1  slave ready / wait-state control.
- `hresp`  out  1  1 = ERROR.
- `hrdata`  out  data_width  read data.
- `paddr`  out  addr_width  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `pwdata`  out  data_width  APB write data.
- `prdata`  in  data_width  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB error.

## Operation
- **Transfer encodings (htrans):**
  - seq = 2'b00 and non_seq = 2'b01 are valid transfers.
  - 2'b10 = IDLE and 2'b11 = BUSY are ignored.
- **Accept condition:** `hsel & hready & htrans∈{seq,non_seq}`, sampled only in states IDLE or ERR2. On accept, haddr→paddr and hwrite→pwrite are registered.
- **FSM states:** IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- **Transitions:**
  - IDLE/ERR2 + accept, hsize≠0 (wider than the 8-bit bus) → ERR1. No APB access is made.
  - IDLE/ERR2 + accept, write → WDATA.
  - IDLE/ERR2 + accept, read → SETUP.
  - No accept → IDLE.
  - WDATA → SETUP. hwdata is captured into pwdata at the end of WDATA.
  - SETUP → ACCESS, unconditionally.
  - ACCESS & !pready → ACCESS.
  - ACCESS & pready & !pslverr → IDLE. For reads, prdata is registered into hrdata.
  - ACCESS & pready & pslverr → ERR1.
  - ERR1 → ERR2.
- **Outputs per state:**
  - psel = 1 in SETUP and ACCESS.
  - penable = 1 only in ACCESS.
  - hreadyout = 0 in WDATA, SETUP, ACCESS and ERR1; 1 in IDLE and ERR2.
  - hresp = 1 in ERR1 and ERR2 (two-cycle AHB error response).
- **Hold rules:**
  - paddr, pwrite and pwdata stay stable from SETUP through the last ACCESS cycle.
  - hrdata holds its value until the next successful read.
  - A write leaves hrdata unchanged.
- **Reset values:** hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, FSM=IDLE.

## Timing
- Address phase accepted at edge E0. Output timing per transfer type:

| Transfer | Edge E1 | Edge E2 | Edge E3 | Completion |
|---|---|---|---|---|
| Read, pready=1 in first ACCESS | SETUP | ACCESS | IDLE, hreadyout=1, hrdata valid | 2 wait states |
| Write | WDATA | SETUP | ACCESS | IDLE at E4; 3 wait states |

- Each ACCESS cycle with pready=0 adds one wait state.
- **Back-to-back transfers:** a new address phase may be presented in the cycle where hreadyout returns to 1 (IDLE). It is accepted at that edge, with no idle cycle between APB transfers beyond SETUP.
- **Error response:**
  - ERR1 drives hresp=1 with hreadyout=0.
  - ERR2 drives hresp=1 with hreadyout=1.
  - An address presented during ERR2 is accepted normally.
- **Reset mid-transfer:** hreset high at any edge forces IDLE and the reset values at that edge. psel/penable drop in the same cycle; the interrupted transfer is not completed.
- **Signal qualification:**
  - pslverr is sampled only when `psel & penable & pready`.
  - prdata is sampled only on a successful read completion.

## Structure
- **Shared package `ahb_apb_pkg`:**
  - `data_width`, `addr_width`.
  - htrans constants `seq`/`non_seq`/`idle`/`busy`.
  - `tr_type_t` {READ, WRITE}.
  - Bridge state enum.
- **Module organisation:** single module, no sub-module. The FSM and output registers are one unit; the APB side is not split out.

## Test plan
- **Single read:** haddr=32'h0000_0010, pready=1, prdata=8'hA5.
  - psel rises at E1; penable at E2.
  - hreadyout=1 and hrdata=8'hA5 at E3.
  - hresp=0 throughout.
- **Single write:** haddr=32'h20, hwdata=8'h3C.
  - paddr=32'h20, pwrite=1, pwdata=8'h3C stable in SETUP and ACCESS.
  - hreadyout low for 3 cycles.
- **Slave wait states:** read with pready low for 3 ACCESS cycles.
  - penable held for 4 cycles; paddr stable.
  - hreadyout low for 5 cycles total.
- **APB error:** write with pslverr=1 at pready.
  - ERR1 (hresp=1, hreadyout=0), then ERR2 (hresp=1, hreadyout=1), then IDLE.
- **Size error and ignored transfers:**
  - hsize=3'b001 → error response with psel never asserted.
  - htrans=2'b10 or 2'b11 → no response change.
- **Back-to-back and reset:**
  - Read then write back-to-back: second address accepted in the completion cycle.
  - Repeat with hreset pulsed during ACCESS: psel/penable=0 and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ahb_apb_bridge_pkg.sv
// ahb_apb_pkg: shared definitions for the AHB-to-APB bridge.
//   data_width / addr_width : default bus widths (8-bit data, 32-bit address)
//   seq / non_seq / idle / busy : htrans encodings used on ahb_inter
//   tr_type_t      : transfer direction
//   bridge_state_t : bridge FSM states
//   valid_htrans() : true for the transfer types that start an APB access
package ahb_apb_pkg;

  localparam int data_width = 8;
  localparam int addr_width = 32;

  // The team's AHB driver uses its own htrans encoding, not the AMBA one.
  localparam logic [1:0] seq     = 2'b00;
  localparam logic [1:0] non_seq = 2'b01;
  localparam logic [1:0] idle    = 2'b10;
  localparam logic [1:0] busy    = 2'b11;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tr_type_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

  function automatic logic valid_htrans(input logic [1:0] t);
    return (t == seq) || (t == non_seq);
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ahb_apb_bridge_if: AHB slave side and APB master side of the bridge.
//   slave  modport : bridge view (AHB request in, AHB response out,
//                    APB request out, APB response in)
//   master modport : environment view (AHB master plus APB peripheral)
//   AHB: hsel, haddr, htrans, hwrite, hsize, hwdata, hready -> bridge
//        hreadyout, hresp, hrdata                           <- bridge
//   APB: paddr, psel, penable, pwrite, pwdata               <- bridge
//        prdata, pready, pslverr                            -> bridge
interface ahb_apb_bridge_if #(
  parameter int data_width = ahb_apb_pkg::data_width,
  parameter int addr_width = ahb_apb_pkg::addr_width
);

  logic                  hsel;
  logic [addr_width-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [data_width-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [data_width-1:0] hrdata;

  logic [addr_width-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [data_width-1:0] pwdata;
  logic [data_width-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB slave that turns each accepted AHB transfer into one
// APB transfer, holding the AHB bus in wait states until the APB access ends.
// One transfer is outstanding at a time.
//   hclk   : clock, all logic on the rising edge
//   hreset : synchronous active-high reset
//   bus    : ahb_apb_bridge_if.slave (AHB request/response, APB request/response)
// Status outputs (psel, penable, hreadyout, hresp) are decoded from the
// registered state, so they change only on clock edges.
module ahb_apb_bridge
  import ahb_apb_pkg::bridge_state_t, ahb_apb_pkg::tr_type_t,
         ahb_apb_pkg::READ, ahb_apb_pkg::WRITE,
         ahb_apb_pkg::ST_IDLE, ahb_apb_pkg::ST_WDATA, ahb_apb_pkg::ST_SETUP,
         ahb_apb_pkg::ST_ACCESS, ahb_apb_pkg::ST_ERR1, ahb_apb_pkg::ST_ERR2,
         ahb_apb_pkg::valid_htrans;
#(
  parameter int data_width = ahb_apb_pkg::data_width,
  parameter int addr_width = ahb_apb_pkg::addr_width
) (
  input  logic             hclk,
  input  logic             hreset,
  ahb_apb_bridge_if.slave  bus
);

  bridge_state_t         r_state;
  tr_type_t              r_dir;
  logic [addr_width-1:0] r_paddr;
  logic [data_width-1:0] r_pwdata;
  logic [data_width-1:0] r_hrdata;

  logic w_accept;
  logic w_size_err;

  // A new address phase is only looked at while the AHB side is ready;
  // ERR2 already drives hreadyout high, so it accepts like IDLE does.
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) &&
                    bus.hsel && bus.hready && valid_htrans(bus.htrans);

  // The APB data path is 8 bits; anything wider is answered with ERROR.
  assign w_size_err = (bus.hsize != 3'd0);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= ST_IDLE;
      r_dir    <= READ;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_hrdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          if (w_accept) begin
            r_paddr <= bus.haddr;
            r_dir   <= tr_type_t'(bus.hwrite);
            if (w_size_err)      r_state <= ST_ERR1;
            else if (bus.hwrite) r_state <= ST_WDATA;
            else                 r_state <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        // hwdata belongs to the AHB data phase, one cycle after the address.
        ST_WDATA: begin
          r_pwdata <= bus.hwdata;
          r_state  <= ST_SETUP;
        end
        ST_SETUP: r_state <= ST_ACCESS;
        // pslverr and prdata only mean something when pready closes the access.
        ST_ACCESS: begin
          if (bus.pready) begin
            if (bus.pslverr) begin
              r_state <= ST_ERR1;
            end else begin
              r_state <= ST_IDLE;
              if (r_dir == READ) r_hrdata <= bus.prdata;
            end
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign bus.penable   = (r_state == ST_ACCESS);
  assign bus.hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign bus.hresp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
  assign bus.hrdata    = r_hrdata;
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = (r_dir == WRITE);
  assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
module tb_ahb_apb_bridge;
  import ahb_apb_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  ahb_apb_bridge_if bus_if ();

  ahb_apb_bridge dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus_if)
  );

  int nvec  = 0;
  int nfail = 0;

  // Reference model state: last successfully read byte.
  logic [7:0] mdl_hrdata;

  // Expected per-transfer figures.
  int e_low, e_psel, e_pen, e_err1, e_err2, e_psel_first;

  // Observations of one transfer, cycle numbers counted from the accept edge.
  int         ob_low, ob_psel, ob_pen, ob_err1, ob_err2, ob_psel_first, ob_pen_first, ob_cycles;
  bit         ob_timeout, ob_unstable, ob_pen_bad, ob_first_low;
  logic [31:0] ob_paddr;
  logic       ob_pwrite;
  logic [7:0] ob_pwdata, ob_hrdata;

  // Transfer-level model: wait states are the cycles spent in WDATA (writes),
  // SETUP, each ACCESS cycle, and ERR1 on an error.
  task automatic model_xfer(input bit wr, input logic [2:0] sz, input int nwait,
                            input bit slverr, input logic [7:0] rd);
    if (sz != 3'd0) begin
      e_low = 1; e_psel = 0; e_pen = 0; e_err1 = 1; e_err2 = 1; e_psel_first = 0;
    end else begin
      e_pen        = nwait + 1;
      e_psel       = e_pen + 1;
      e_psel_first = wr ? 2 : 1;
      e_err1       = slverr ? 1 : 0;
      e_err2       = e_err1;
      e_low        = (wr ? 1 : 0) + e_psel + e_err1;
      if (!wr && !slverr) mdl_hrdata = rd;
    end
  endtask

  // Acts as AHB master and APB peripheral for one transfer. Must be entered
  // after a falling edge; returns at the falling edge of the completion
  // cycle (IDLE, or ERR2 when stop_err2 is set) so the caller may present
  // the next address phase straight away.
  task automatic run_xfer(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [7:0] wd, input int nwait, input bit slverr,
                          input logic [7:0] rd, input bit stop_err2);
    int acc;
    bit done;
    bus_if.hsel = 1'b1; bus_if.hready = 1'b1; bus_if.htrans = non_seq;
    bus_if.haddr = addr; bus_if.hwrite = wr; bus_if.hsize = sz; bus_if.hwdata = wd;
    ob_low = 0; ob_psel = 0; ob_pen = 0; ob_err1 = 0; ob_err2 = 0;
    ob_psel_first = 0; ob_pen_first = 0; ob_cycles = 0;
    ob_timeout = 0; ob_unstable = 0; ob_pen_bad = 0; ob_first_low = 0;
    ob_paddr = '0; ob_pwrite = 1'b0; ob_pwdata = '0; ob_hrdata = '0;
    @(posedge hclk); #1;
    bus_if.hsel = 1'b0; bus_if.htrans = idle;
    bus_if.haddr = $urandom; bus_if.hwrite = 1'($urandom); bus_if.hsize = 3'($urandom);
    acc = 0; done = 0;
    for (int c = 1; c <= 64 && !done; c++) begin
      @(negedge hclk);
      ob_cycles = c;
      if (c == 1) ob_first_low = !bus_if.hreadyout;
      if (c >= 2) bus_if.hwdata = $urandom;
      if (bus_if.psel) begin
        ob_psel++;
        if (ob_psel == 1) begin
          ob_psel_first = c; ob_paddr = bus_if.paddr;
          ob_pwrite = bus_if.pwrite; ob_pwdata = bus_if.pwdata;
        end else if (bus_if.paddr !== ob_paddr || bus_if.pwrite !== ob_pwrite ||
                     bus_if.pwdata !== ob_pwdata) begin
          ob_unstable = 1;
        end
      end
      if (bus_if.penable) begin
        ob_pen++;
        if (ob_pen == 1) ob_pen_first = c;
        if (!bus_if.psel) ob_pen_bad = 1;
      end
      if (!bus_if.hreadyout) ob_low++;
      if (bus_if.hresp && !bus_if.hreadyout) ob_err1++;
      if (bus_if.hresp && bus_if.hreadyout) ob_err2++;
      if (bus_if.psel && bus_if.penable) begin
        acc++;
        if (acc > nwait) begin
          bus_if.pready = 1'b1; bus_if.pslverr = slverr; bus_if.prdata = rd;
        end else begin
          bus_if.pready = 1'b0; bus_if.pslverr = 1'($urandom); bus_if.prdata = $urandom;
        end
      end else begin
        bus_if.pready = 1'b0; bus_if.pslverr = 1'($urandom); bus_if.prdata = $urandom;
      end
      if (bus_if.hreadyout && (!bus_if.hresp || stop_err2)) begin
        done = 1; ob_hrdata = bus_if.hrdata;
      end
    end
    bus_if.pready = 1'b0;
    if (!done) ob_timeout = 1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    bus_if.hsel = 1'b1; bus_if.hready = 1'b1; bus_if.htrans = non_seq;
    bus_if.haddr = 32'hFFFF_FFFF; bus_if.hwrite = 1'b1; bus_if.hsize = 3'd0;
    bus_if.hwdata = 8'hFF; bus_if.pready = 1'b1; bus_if.pslverr = 1'b1; bus_if.prdata = 8'hFF;
    repeat (3) @(negedge hclk);
    bus_if.hsel = 1'b0; bus_if.htrans = idle; bus_if.pready = 1'b0; bus_if.pslverr = 1'b0;
    hreset = 1'b0;
    mdl_hrdata = 8'h00;
    nvec++; if (bus_if.hreadyout !== 1'b1) begin nfail++; $display("FAIL rst_hreadyout got=%b exp=1", bus_if.hreadyout); end
    nvec++; if (bus_if.hresp !== 1'b0) begin nfail++; $display("FAIL rst_hresp got=%b exp=0", bus_if.hresp); end
    nvec++; if (bus_if.hrdata !== 8'h00) begin nfail++; $display("FAIL rst_hrdata got=%h exp=00", bus_if.hrdata); end
    nvec++; if (bus_if.psel !== 1'b0) begin nfail++; $display("FAIL rst_psel got=%b exp=0", bus_if.psel); end
    nvec++; if (bus_if.penable !== 1'b0) begin nfail++; $display("FAIL rst_penable got=%b exp=0", bus_if.penable); end
    nvec++; if (bus_if.pwrite !== 1'b0) begin nfail++; $display("FAIL rst_pwrite got=%b exp=0", bus_if.pwrite); end
    nvec++; if (bus_if.paddr !== 32'h0) begin nfail++; $display("FAIL rst_paddr got=%h exp=0", bus_if.paddr); end
    nvec++; if (bus_if.pwdata !== 8'h00) begin nfail++; $display("FAIL rst_pwdata got=%h exp=00", bus_if.pwdata); end
  endtask

  task automatic test_single_read();
    run_xfer(1'b0, 3'd0, 32'h0000_0010, 8'h00, 0, 1'b0, 8'hA5, 1'b0);
    nvec++; if (ob_psel_first !== 1) begin nfail++; $display("FAIL rd_psel_cycle got=%0d exp=1", ob_psel_first); end
    nvec++; if (ob_pen_first !== 2) begin nfail++; $display("FAIL rd_penable_cycle got=%0d exp=2", ob_pen_first); end
    nvec++; if (ob_cycles !== 3 || ob_timeout) begin nfail++; $display("FAIL rd_done_cycle got=%0d exp=3", ob_cycles); end
    nvec++; if (ob_low !== 2) begin nfail++; $display("FAIL rd_wait_states got=%0d exp=2", ob_low); end
    nvec++; if (ob_hrdata !== 8'hA5) begin nfail++; $display("FAIL rd_hrdata got=%h exp=a5", ob_hrdata); end
    nvec++; if (ob_err1 + ob_err2 !== 0) begin nfail++; $display("FAIL rd_hresp got=%0d cycles exp=0", ob_err1 + ob_err2); end
    nvec++; if (ob_paddr !== 32'h10 || ob_pwrite !== 1'b0) begin nfail++; $display("FAIL rd_paddr got=%h/%b exp=10/0", ob_paddr, ob_pwrite); end
    mdl_hrdata = 8'hA5;
  endtask

  task automatic test_single_write();
    run_xfer(1'b1, 3'd0, 32'h0000_0020, 8'h3C, 0, 1'b0, 8'h77, 1'b0);
    nvec++; if (ob_low !== 3 || ob_timeout) begin nfail++; $display("FAIL wr_wait_states got=%0d exp=3", ob_low); end
    nvec++; if (ob_psel_first !== 2 || ob_psel !== 2) begin nfail++; $display("FAIL wr_psel got first=%0d n=%0d exp 2/2", ob_psel_first, ob_psel); end
    nvec++; if (ob_paddr !== 32'h20 || ob_pwrite !== 1'b1 || ob_pwdata !== 8'h3C) begin nfail++; $display("FAIL wr_apb got=%h/%b/%h exp=20/1/3c", ob_paddr, ob_pwrite, ob_pwdata); end
    nvec++; if (ob_unstable) begin nfail++; $display("FAIL wr_stable got=changed exp=stable"); end
    nvec++; if (ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL wr_hrdata_hold got=%h exp=%h", ob_hrdata, mdl_hrdata); end
  endtask

  task automatic test_wait_states();
    logic [31:0] a;
    logic [7:0]  d;
    a = $urandom; d = 8'($urandom);
    model_xfer(1'b0, 3'd0, 3, 1'b0, d);
    run_xfer(1'b0, 3'd0, a, 8'h00, 3, 1'b0, d, 1'b0);
    nvec++; if (ob_pen !== e_pen) begin nfail++; $display("FAIL ws_penable got=%0d exp=%0d", ob_pen, e_pen); end
    nvec++; if (ob_low !== e_low || ob_timeout) begin nfail++; $display("FAIL ws_wait_states got=%0d exp=%0d", ob_low, e_low); end
    nvec++; if (ob_unstable || ob_paddr !== a) begin nfail++; $display("FAIL ws_paddr got=%h exp=%h", ob_paddr, a); end
    nvec++; if (ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL ws_hrdata got=%h exp=%h", ob_hrdata, mdl_hrdata); end
  endtask

  task automatic test_apb_error();
    // Write with error after one slave wait state.
    model_xfer(1'b1, 3'd0, 1, 1'b1, 8'h00);
    run_xfer(1'b1, 3'd0, 32'h40, 8'h5A, 1, 1'b1, 8'h00, 1'b0);
    nvec++; if (ob_err1 !== 1 || ob_err2 !== 1) begin nfail++; $display("FAIL err_hresp got=%0d/%0d exp=1/1", ob_err1, ob_err2); end
    nvec++; if (ob_low !== e_low) begin nfail++; $display("FAIL err_wait_states got=%0d exp=%0d", ob_low, e_low); end
    nvec++; if (ob_cycles !== e_low + 2 || ob_timeout) begin nfail++; $display("FAIL err_idle_cycle got=%0d exp=%0d", ob_cycles, e_low + 2); end
    // Read with error must not disturb hrdata.
    model_xfer(1'b0, 3'd0, 0, 1'b1, 8'hEE);
    run_xfer(1'b0, 3'd0, 32'h44, 8'h00, 0, 1'b1, 8'hEE, 1'b0);
    nvec++; if (ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL err_rd_hrdata got=%h exp=%h", ob_hrdata, mdl_hrdata); end
    nvec++; if (ob_err1 !== 1 || ob_err2 !== 1) begin nfail++; $display("FAIL err_rd_hresp got=%0d/%0d exp=1/1", ob_err1, ob_err2); end
  endtask

  task automatic test_size_error();
    run_xfer(1'b0, 3'b001, 32'h50, 8'h00, 0, 1'b0, 8'h11, 1'b0);
    nvec++; if (ob_psel !== 0) begin nfail++; $display("FAIL sz_psel got=%0d cycles exp=0", ob_psel); end
    nvec++; if (ob_err1 !== 1 || ob_err2 !== 1 || ob_low !== 1) begin nfail++; $display("FAIL sz_resp got=%0d/%0d/%0d exp=1/1/1", ob_err1, ob_err2, ob_low); end
    run_xfer(1'b1, 3'b010, 32'h54, 8'h22, 0, 1'b0, 8'h00, 1'b0);
    nvec++; if (ob_psel !== 0 || ob_err1 !== 1 || ob_err2 !== 1) begin nfail++; $display("FAIL sz_wr got=%0d/%0d/%0d exp=0/1/1", ob_psel, ob_err1, ob_err2); end
    nvec++; if (ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL sz_hrdata got=%h exp=%h", ob_hrdata, mdl_hrdata); end
  endtask

  task automatic test_ignored();
    logic [1:0] tr;
    logic       sel, rdy;
    for (int k = 0; k < 4; k++) begin
      tr  = (k == 0) ? idle : (k == 1) ? busy : non_seq;
      sel = (k != 3);
      rdy = (k != 2);
      bus_if.hsel = sel; bus_if.hready = rdy; bus_if.htrans = tr;
      bus_if.haddr = $urandom; bus_if.hwrite = 1'($urandom); bus_if.hsize = 3'd0;
      @(posedge hclk); #1;
      bus_if.hsel = 1'b0; bus_if.hready = 1'b1; bus_if.htrans = idle;
      @(negedge hclk);
      nvec++; if (bus_if.hreadyout !== 1'b1 || bus_if.hresp !== 1'b0 || bus_if.psel !== 1'b0) begin
        nfail++; $display("FAIL ignored_%0d got=rdy%b resp%b psel%b exp=rdy1 resp0 psel0", k, bus_if.hreadyout, bus_if.hresp, bus_if.psel);
      end
    end
  endtask

  task automatic test_back_to_back();
    model_xfer(1'b0, 3'd0, 0, 1'b0, 8'h81);
    run_xfer(1'b0, 3'd0, 32'h100, 8'h00, 0, 1'b0, 8'h81, 1'b0);
    run_xfer(1'b1, 3'd0, 32'h104, 8'h92, 0, 1'b0, 8'h00, 1'b0);
    nvec++; if (!ob_first_low || ob_psel_first !== 2) begin nfail++; $display("FAIL b2b_wr_accept got=%b/%0d exp=1/2", ob_first_low, ob_psel_first); end
    nvec++; if (ob_paddr !== 32'h104 || ob_pwdata !== 8'h92) begin nfail++; $display("FAIL b2b_wr_apb got=%h/%h exp=104/92", ob_paddr, ob_pwdata); end
    // Size error, then a read presented during ERR2.
    run_xfer(1'b0, 3'b011, 32'h108, 8'h00, 0, 1'b0, 8'h00, 1'b1);
    model_xfer(1'b0, 3'd0, 0, 1'b0, 8'h6D);
    run_xfer(1'b0, 3'd0, 32'h10C, 8'h00, 0, 1'b0, 8'h6D, 1'b0);
    nvec++; if (!ob_first_low || ob_low !== 2 || ob_paddr !== 32'h10C) begin nfail++; $display("FAIL err2_accept got=%b/%0d/%h exp=1/2/10c", ob_first_low, ob_low, ob_paddr); end
    nvec++; if (ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL err2_rd_hrdata got=%h exp=%h", ob_hrdata, mdl_hrdata); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    model_xfer(1'b0, 3'd0, 0, 1'b0, 8'hB4);
    run_xfer(1'b0, 3'd0, 32'h200, 8'h00, 0, 1'b0, 8'hB4, 1'b0);
    // Write presented in the completion cycle, then reset during ACCESS.
    bus_if.hsel = 1'b1; bus_if.hready = 1'b1; bus_if.htrans = non_seq;
    bus_if.haddr = 32'h204; bus_if.hwrite = 1'b1; bus_if.hsize = 3'd0; bus_if.hwdata = 8'hC3;
    @(posedge hclk); #1;
    bus_if.hsel = 1'b0; bus_if.htrans = idle;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge hclk);
      bus_if.pready = 1'b0;
      if (bus_if.psel && bus_if.penable) hit = 1;
    end
    nvec++; if (!hit) begin nfail++; $display("FAIL rstmid_access got=none exp=access"); end
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    mdl_hrdata = 8'h00;
    nvec++; if (bus_if.psel !== 1'b0 || bus_if.penable !== 1'b0) begin nfail++; $display("FAIL rstmid_apb got=%b/%b exp=0/0", bus_if.psel, bus_if.penable); end
    nvec++; if (bus_if.hreadyout !== 1'b1 || bus_if.hresp !== 1'b0) begin nfail++; $display("FAIL rstmid_ahb got=%b/%b exp=1/0", bus_if.hreadyout, bus_if.hresp); end
    nvec++; if (bus_if.hrdata !== 8'h00) begin nfail++; $display("FAIL rstmid_hrdata got=%h exp=00", bus_if.hrdata); end
    nvec++; if (bus_if.paddr !== 32'h0 || bus_if.pwrite !== 1'b0 || bus_if.pwdata !== 8'h00) begin
      nfail++; $display("FAIL rstmid_apb_regs got=%h/%b/%h exp=0/0/00", bus_if.paddr, bus_if.pwrite, bus_if.pwdata);
    end
    model_xfer(1'b0, 3'd0, 1, 1'b0, 8'h3E);
    run_xfer(1'b0, 3'd0, 32'h208, 8'h00, 1, 1'b0, 8'h3E, 1'b0);
    nvec++; if (ob_low !== e_low || ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL rstmid_recover got=%0d/%h exp=%0d/%h", ob_low, ob_hrdata, e_low, mdl_hrdata); end
  endtask

  task automatic test_random();
    bit          wr, slv, stop;
    logic [2:0]  sz;
    int          nw;
    logic [31:0] a;
    logic [7:0]  wd, rd;
    for (int it = 0; it < 40; it++) begin
      wr   = 1'($urandom);
      sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      nw   = $urandom_range(0, 3);
      slv  = ($urandom_range(0, 4) == 0);
      stop = 1'($urandom);
      a = $urandom; wd = 8'($urandom); rd = 8'($urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge hclk);
      model_xfer(wr, sz, nw, slv, rd);
      run_xfer(wr, sz, a, wd, nw, slv, rd, stop);
      nvec++; if (ob_timeout) begin nfail++; $display("FAIL rnd%0d_timeout got=no completion exp=completion", it); end
      nvec++; if (ob_low !== e_low) begin nfail++; $display("FAIL rnd%0d_wait_states got=%0d exp=%0d", it, ob_low, e_low); end
      nvec++; if (ob_psel !== e_psel || ob_pen !== e_pen || ob_pen_bad) begin
        nfail++; $display("FAIL rnd%0d_apb_cycles got=%0d/%0d exp=%0d/%0d", it, ob_psel, ob_pen, e_psel, e_pen);
      end
      nvec++; if (ob_err1 !== e_err1 || ob_err2 !== e_err2) begin nfail++; $display("FAIL rnd%0d_hresp got=%0d/%0d exp=%0d/%0d", it, ob_err1, ob_err2, e_err1, e_err2); end
      nvec++; if (ob_hrdata !== mdl_hrdata) begin nfail++; $display("FAIL rnd%0d_hrdata got=%h exp=%h", it, ob_hrdata, mdl_hrdata); end
      if (sz == 3'd0) begin
        nvec++; if (ob_psel_first !== e_psel_first || ob_unstable || ob_paddr !== a || ob_pwrite !== wr) begin
          nfail++; $display("FAIL rnd%0d_apb_req got=%0d/%h/%b exp=%0d/%h/%b", it, ob_psel_first, ob_paddr, ob_pwrite, e_psel_first, a, wr);
        end
        if (wr) begin
          nvec++; if (ob_pwdata !== wd) begin nfail++; $display("FAIL rnd%0d_pwdata got=%h exp=%h", it, ob_pwdata, wd); end
        end
      end
    end
  endtask

  initial begin
    hreset = 1'b1;
    bus_if.hsel = 1'b0; bus_if.hready = 1'b1; bus_if.htrans = idle; bus_if.haddr = '0;
    bus_if.hwrite = 1'b0; bus_if.hsize = 3'd0; bus_if.hwdata = '0;
    bus_if.prdata = '0; bus_if.pready = 1'b0; bus_if.pslverr = 1'b0;
    mdl_hrdata = 8'h00;
    test_reset();
    test_single_read();
    test_single_write();
    test_wait_states();
    test_apb_error();
    test_size_error();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
